// File: rtl/current_limit_monitor_if.sv
// rtl/current_limit_monitor_if.sv - tagged current sample stream from the ADC sequencer
interface current_limit_monitor_if;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [15:0] sample_data;
    logic        sample_ready;

    // Sequencer side: drives samples, sees back-pressure.
    modport master (
        output sample_valid,
        output sample_ch,
        output sample_data,
        input  sample_ready
    );

    // Monitor side: consumes samples.
    modport slave (
        input  sample_valid,
        input  sample_ch,
        input  sample_data,
        output sample_ready
    );
endinterface

// File: rtl/current_limit_monitor.sv
// rtl/current_limit_monitor.sv - DDS/CW/ADC over-current debounce, fault latch and shutdown (option: CURRENT_MON_AUTO_RETRY_EN)
module current_limit_monitor #(
    parameter int TRIP_COUNT   = 8,
    parameter int RETRY_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     start_rst,
    input  logic [15:0]              dds_current_limit,
    input  logic [15:0]              cw_current_limit,
    input  logic [15:0]              adc_current_limit,
    input  logic                     monitor_en,
    input  logic                     clear,
    current_limit_monitor_if.slave   smp,
    output logic [7:0]               status,
    output logic                     shutdown,
    output logic                     fault_irq
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ARMED    = 2'b01,
        TRIPPED  = 2'b10,
        CLEARING = 2'b11
    } state_t;

    localparam logic [3:0] TRIP_C = 4'(TRIP_COUNT);

    state_t            state_q;
    logic              en_s1_q, en_s2_q;
    logic              clr_s1_q, clr_s2_q, clr_s3_q;
    logic [2:0][15:0]  lim_raw;
    logic [2:0][15:0]  lim_s1_q, lim_s2_q, lim_sh_q;
    logic [2:0][3:0]   cnt_q, cnt_d;
    logic [2:0]        trip_ch;
    logic [2:0]        fault_q;
    logic              illegal_q;
    logic              shutdown_q, fault_irq_q, sample_ready_q;
    logic              accept, clear_edge, retry_done;

    // Index 0 = DDS, 1 = CW, 2 = ADC, matching the sample channel tags.
    assign lim_raw    = {adc_current_limit, cw_current_limit, dds_current_limit};
    assign accept     = smp.sample_valid & sample_ready_q;
    assign clear_edge = clr_s2_q & ~clr_s3_q;

    assign smp.sample_ready = sample_ready_q;
    assign shutdown         = shutdown_q;
    assign fault_irq        = fault_irq_q;
    assign status           = {state_q, shutdown_q, illegal_q, |fault_q, fault_q};

    // Bring enable and clear into the clk domain; third clear flop is the edge-detect history.
    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            en_s1_q  <= 1'b0;
            en_s2_q  <= 1'b0;
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
            clr_s3_q <= 1'b0;
        end else begin
            en_s1_q  <= monitor_en;
            en_s2_q  <= en_s1_q;
            clr_s1_q <= clear;
            clr_s2_q <= clr_s1_q;
            clr_s3_q <= clr_s2_q;
        end
    end

    // Limit shadows load only once two consecutive samples of the SCL-domain bus agree,
    // so a multi-bit bus caught mid-update is never used.
    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            lim_s1_q <= '0;
            lim_s2_q <= '0;
            lim_sh_q <= '0;
        end else begin
            lim_s1_q <= lim_raw;
            lim_s2_q <= lim_s1_q;
            for (int c = 0; c < 3; c++) begin
                if (lim_s1_q[c] == lim_s2_q[c]) begin
                    lim_sh_q[c] <= lim_s2_q[c];
                end
            end
        end
    end

    // Debounce evaluation of the accepted sample; a zero limit disables its channel.
    always_comb begin
        cnt_d   = cnt_q;
        trip_ch = '0;
        for (int c = 0; c < 3; c++) begin
            if (state_q == ARMED && accept && smp.sample_ch == 2'(c)) begin
                if (lim_sh_q[c] != 16'd0 && smp.sample_data > lim_sh_q[c]) begin
                    if (cnt_q[c] >= TRIP_C) begin
                        cnt_d[c] = TRIP_C;
                    end else begin
                        cnt_d[c] = cnt_q[c] + 4'd1;
                    end
                    if (cnt_d[c] == TRIP_C) begin
                        trip_ch[c] = 1'b1;
                    end
                end else begin
                    cnt_d[c] = 4'd0;
                end
            end
        end
    end

`ifdef CURRENT_MON_AUTO_RETRY_EN
    logic [15:0] retry_q;
    assign retry_done = (retry_q == 16'(RETRY_CYCLES - 1));
`else
    // Auto-retry not built: RETRY_CYCLES is never negative, so this is a constant 0.
    assign retry_done = (RETRY_CYCLES < 0);
`endif

    // Monitor FSM with counters, fault latches and registered outputs.
    always_ff @(posedge clk or posedge start_rst) begin
        if (start_rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            fault_q        <= '0;
            illegal_q      <= 1'b0;
            shutdown_q     <= 1'b0;
            fault_irq_q    <= 1'b0;
            sample_ready_q <= 1'b1;
`ifdef CURRENT_MON_AUTO_RETRY_EN
            retry_q        <= '0;
`endif
        end else begin
            fault_irq_q <= 1'b0;
            if (accept && smp.sample_ch == 2'd3) begin
                illegal_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (en_s2_q) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (|trip_ch) begin
                        // A trip outranks a coincident clear edge, which is simply dropped.
                        cnt_q       <= cnt_d;
                        state_q     <= TRIPPED;
                        fault_q     <= fault_q | trip_ch;
                        fault_irq_q <= 1'b1;
                        shutdown_q  <= 1'b1;
`ifdef CURRENT_MON_AUTO_RETRY_EN
                        retry_q     <= '0;
`endif
                    end else if (!en_s2_q) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                TRIPPED: begin
`ifdef CURRENT_MON_AUTO_RETRY_EN
                    retry_q <= retry_q + 16'd1;
`endif
                    if (clear_edge || retry_done) begin
                        state_q        <= CLEARING;
                        shutdown_q     <= 1'b0;
                        sample_ready_q <= 1'b0;
                    end
                end
                CLEARING: begin
                    cnt_q          <= '0;
                    fault_q        <= '0;
                    illegal_q      <= 1'b0;
                    sample_ready_q <= 1'b1;
                    state_q        <= en_s2_q ? ARMED : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_current_limit_monitor.sv
// tb/tb_current_limit_monitor.sv - scoreboard bench for current_limit_monitor
module tb_current_limit_monitor;
    logic        clk = 1'b0;
    logic        start_rst;
    logic [15:0] dds_lim, cw_lim, adc_lim;
    logic        en, clr;
    logic [7:0]  status;
    logic        shutdown, fault_irq;

    current_limit_monitor_if smp();

    current_limit_monitor #(.TRIP_COUNT(8), .RETRY_CYCLES(16)) dut (
        .clk               (clk),
        .start_rst         (start_rst),
        .dds_current_limit (dds_lim),
        .cw_current_limit  (cw_lim),
        .adc_current_limit (adc_lim),
        .monitor_en        (en),
        .clear             (clr),
        .smp               (smp),
        .status            (status),
        .shutdown          (shutdown),
        .fault_irq         (fault_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] st;
        logic       irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic acc = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Record whether a sample was accepted on this edge.
    always @(posedge clk) acc = smp.sample_valid && smp.sample_ready && !start_rst;

    // Scoreboard monitor: each accepted sample pops one expected response.
    always @(negedge clk) begin
        if (acc) begin
            if (exp_q.size() == 0) begin
                check("unexpected_accept", 16'd1, 16'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sample_status", 16'(status), 16'(mon_e.st));
                check("sample_irq", 16'(fault_irq), 16'(mon_e.irq));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [15:0] data,
                        input logic [7:0] st, input logic irq);
        exp_t e;
        e.st  = st;
        e.irq = irq;
        exp_q.push_back(e);
        smp.sample_valid = 1'b1;
        smp.sample_ch    = ch;
        smp.sample_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n, input logic [1:0] ch, input logic [15:0] data,
                          input logic [7:0] st);
        for (int i = 0; i < n; i++) send(ch, data, st, 1'b0);
    endtask

    task automatic idle();
        smp.sample_valid = 1'b0;
    endtask

    // Wait (bounded) for the one-cycle CLEARING window, then check the state that follows.
    task automatic expect_clearing(input logic [7:0] st_after);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!smp.sample_ready) begin
                found = 1'b1;
                break;
            end
        end
        check("clearing_seen", 16'(found), 16'd1);
        if (found) begin
            check("clearing_code", 16'(status[7:6]), 16'd3);
            @(negedge clk);
            check("after_clear_ready", 16'(smp.sample_ready), 16'd1);
            check("after_clear_status", 16'(status), 16'(st_after));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        start_rst = 1'b1;
        dds_lim = 16'h0; cw_lim = 16'h0; adc_lim = 16'h0;
        en = 1'b0; clr = 1'b0;
        smp.sample_valid = 1'b0; smp.sample_ch = 2'd0; smp.sample_data = 16'h0;

        // Reset values.
        tick(2);
        @(negedge clk);
        check("rst_status", 16'(status), 16'h00);
        check("rst_shutdown", 16'(shutdown), 16'd0);
        check("rst_ready", 16'(smp.sample_ready), 16'd1);
        check("rst_irq", 16'(fault_irq), 16'd0);
        @(posedge clk); #1;
        start_rst = 1'b0;

        // Arm with DDS limit 0x0100.
        dds_lim = 16'h0100;
        en = 1'b1;
        tick(5);
        @(negedge clk);
        check("armed_status", 16'(status), 16'h40);
        @(posedge clk); #1;

        // Equal-to-limit sample breaks the run; the eighth consecutive over-limit trips.
        send_n(7, 2'd0, 16'h0200, 8'h40);
        send(2'd0, 16'h0100, 8'h40, 1'b0);
        send_n(7, 2'd0, 16'h0200, 8'h40);
        send(2'd0, 16'h0200, 8'hA9, 1'b1);
        idle();
        @(negedge clk);
        @(negedge clk);
        check("irq_single_pulse", 16'(fault_irq), 16'd0);
        check("tripped_shutdown", 16'(shutdown), 16'd1);
        @(posedge clk); #1;

        // Samples while tripped are accepted and discarded.
        send(2'd0, 16'h0200, 8'hA9, 1'b0);
        idle();

        // Clear edge -> CLEARING -> ARMED.
        clr = 1'b1;
        expect_clearing(8'h40);
        clr = 1'b0;

        // Eight DDS samples just over the limit.
        send_n(7, 2'd0, 16'h0101, 8'h40);
        send(2'd0, 16'h0101, 8'hA9, 1'b1);
        idle();
        clr = 1'b1;
        expect_clearing(8'h40);
        clr = 1'b0;

        // CW limit 0 disables the channel; illegal tag sets the sticky bit.
        send_n(20, 2'd1, 16'hFFFF, 8'h40);
        send(2'd3, 16'h1234, 8'h50, 1'b0);
        idle();

        // Limit change while armed keeps the running count.
        adc_lim = 16'h0010;
        tick(4);
        send_n(3, 2'd2, 16'h0011, 8'h50);
        idle();
        adc_lim = 16'h0020;
        tick(4);
        send_n(4, 2'd2, 16'h0021, 8'h50);
        send(2'd2, 16'h0021, 8'hBC, 1'b1);
        idle();

        // Dropping enable does not leave TRIPPED; clearing then lands in IDLE.
        en = 1'b0;
        tick(6);
        @(negedge clk);
        check("tripped_en0_status", 16'(status), 16'hBC);
        check("tripped_en0_shutdown", 16'(shutdown), 16'd1);
        @(posedge clk); #1;
        clr = 1'b1;
        expect_clearing(8'h00);
        clr = 1'b0;

        // IDLE discards samples without counting.
        send_n(10, 2'd0, 16'hFFFF, 8'h00);
        idle();

        // Re-arm, build a partial count, then reset mid-operation.
        en = 1'b1;
        tick(5);
        send_n(5, 2'd0, 16'h0101, 8'h40);
        idle();
        @(negedge clk);
        #1;
        start_rst = 1'b1;
        #1;
        check("midrst_status", 16'(status), 16'h00);
        check("midrst_shutdown", 16'(shutdown), 16'd0);
        check("midrst_ready", 16'(smp.sample_ready), 16'd1);
        @(posedge clk); #1;
        start_rst = 1'b0;
        tick(6);
        send_n(7, 2'd0, 16'h0101, 8'h40);
        send(2'd0, 16'h0101, 8'hA9, 1'b1);
        idle();

        tick(3);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
